// File: rtl/nios_pio_in_capture_if.sv
// Avalon-MM slave bus bundle for the input-capture PIO.
// The CPU side drives the strobes; the PIO returns zero-latency read data.
interface nios_pio_in_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_pio_in_capture.sv
// Input PIO: synchronizes in_port, latches selected edges into a sticky W1C register,
// and drives a registered, maskable interrupt.
module nios_pio_in_capture #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned IRQ_TYPE    = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_pio_in_capture_if.slave          bus,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    localparam logic [2:0] ArmDone = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [2:0]       arm_q, arm_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr;
    logic             armed;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic             unused_wd;

    assign data_reg  = sync_q[SYNC_STAGES-1];
    assign armed     = (arm_q == ArmDone);
    assign wr_en     = bus.chipselect && !bus.write_n;
    assign unused_wd = ^bus.writedata;

    always_comb begin
        unique case (EDGE_TYPE)
            0:       edges = data_reg & ~prev_q;
            1:       edges = ~data_reg & prev_q;
            default: edges = (data_reg & ~prev_q) | (~data_reg & prev_q);
        endcase
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        clr        = '0;
        if (wr_en && bus.address == 2'd2) begin
            irq_mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == 2'd3) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        // Set is applied after clear so a coincident edge keeps its bit.
        edge_cap_d = (edge_cap_q & ~clr) | (armed ? edges : '0);
        arm_d      = armed ? arm_q : arm_q + 3'd1;
        if (IRQ_TYPE == 1) begin
            irq_d = |(edge_cap_q & irq_mask_q);
        end else begin
            irq_d = |(data_reg & irq_mask_q);
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.address)
            2'd0:    rd_word[WIDTH-1:0] = data_reg;
            2'd2:    rd_word[WIDTH-1:0] = irq_mask_q;
            2'd3:    rd_word[WIDTH-1:0] = edge_cap_q;
            default: rd_word = '0;
        endcase
    end

    assign bus.readdata = rd_word;
    assign irq          = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            arm_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q     <= data_reg;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            arm_q      <= arm_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_nios_pio_in_capture.sv
// Directed bench for the input-capture PIO: stimulus queues expectations, a negedge
// monitor compares them against the two DUT configurations.
module tb_nios_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in0 = '0;
    logic [7:0]  in1 = '0;
    logic        irq0, irq1;

    nios_pio_in_capture_if bus0 ();
    nios_pio_in_capture_if bus1 ();

    always #5 clk = ~clk;

    nios_pio_in_capture #(
        .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .in_port (in0),
        .irq     (irq0)
    );

    nios_pio_in_capture #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(0)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1),
        .in_port (in1),
        .irq     (irq1)
    );

    typedef struct {
        string       name;
        int          dut;
        int          kind;   // 0: readdata, 1: irq
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            if (e.kind == 0) act = (e.dut == 0) ? bus0.readdata : bus1.readdata;
            else             act = (e.dut == 0) ? {31'd0, irq0} : {31'd0, irq1};
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int d);
        if (d == 0) begin bus0.chipselect = 1'b0; bus0.write_n = 1'b1; end
        else        begin bus1.chipselect = 1'b0; bus1.write_n = 1'b1; end
    endtask

    task automatic rd(int d, logic [1:0] a, logic [31:0] exp, string nm);
        exp_t e;
        if (d == 0) begin
            bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
        end else begin
            bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1;
        end
        e.name = nm; e.dut = d; e.kind = 0; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk_irq(int d, logic exp, string nm);
        exp_t e;
        e.name = nm; e.dut = d; e.kind = 1; e.exp = {31'd0, exp};
        sb_q.push_back(e);
    endtask

    task automatic wr(int d, logic [1:0] a, logic [31:0] data);
        if (d == 0) begin
            bus0.address = a; bus0.writedata = data;
            bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus1.address = a; bus1.writedata = data;
            bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
        end
        cyc();
        idle(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus0.address = '0; bus0.writedata = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus1.address = '0; bus1.writedata = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
        in0 = 32'h0000_00FF;
        in1 = 8'h00;
        reset_n = 1'b0;
        cyc();
        cyc();
        rd(0, 2'd0, 32'h0, "in_reset_data");
        chk_irq(0, 1'b0, "in_reset_irq");
        cyc();

        // Release with inputs already high: data appears, no capture.
        reset_n = 1'b1;
        rd(0, 2'd0, 32'h0, "rel_data_c0");
        cyc();
        rd(0, 2'd0, 32'h0, "rel_data_c1");
        cyc();
        rd(0, 2'd0, 32'h0000_00FF, "rel_data_c2");
        cyc();
        for (int i = 0; i < 10; i++) begin
            rd(0, 2'd3, 32'h0, "arm_no_capture");
            cyc();
        end
        rd(0, 2'd1, 32'h0, "reserved_read");
        cyc();

        // Falling edges do not capture in rising mode.
        in0 = 32'h0;
        repeat (4) cyc();
        rd(0, 2'd3, 32'h0, "fall_ignored");
        cyc();

        // Rising edge on 0x5 at edge k.
        in0 = 32'h5;
        cyc();
        rd(0, 2'd0, 32'h0, "rise_data_k");
        cyc();
        rd(0, 2'd0, 32'h5, "rise_data_k1");
        cyc();
        rd(0, 2'd3, 32'h5, "rise_cap_k2");
        chk_irq(0, 1'b0, "rise_irq_unmasked");
        cyc();
        in0 = 32'h0;
        repeat (4) cyc();
        rd(0, 2'd3, 32'h5, "cap_sticky");
        cyc();

        // Mask enables irq one cycle after the write.
        idle(0);
        wr(0, 2'd2, 32'h4);
        chk_irq(0, 1'b0, "irq_at_mask_edge");
        rd(0, 2'd2, 32'h4, "mask_read");
        cyc();
        chk_irq(0, 1'b1, "irq_after_mask");
        cyc();
        idle(0);
        wr(0, 2'd3, 32'h4);
        rd(0, 2'd3, 32'h1, "w1c_bit2");
        chk_irq(0, 1'b1, "irq_at_clear_edge");
        cyc();
        chk_irq(0, 1'b0, "irq_after_clear");
        cyc();

        // Clear of bit 0 coincides with a new rising edge on bit 0.
        in0 = 32'h1;
        cyc();
        cyc();
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h1, "set_beats_clear");
        cyc();
        idle(0);
        wr(0, 2'd3, 32'h0);
        rd(0, 2'd3, 32'h1, "clear_zero_noop");
        cyc();
        idle(0);
        wr(0, 2'd0, 32'hFFFF_FFFF);
        rd(0, 2'd0, 32'h1, "data_write_ignored");
        cyc();

        // Multiple bits rising together.
        idle(0);
        wr(0, 2'd3, 32'hFFFF_FFFF);
        rd(0, 2'd3, 32'h0, "clear_all");
        cyc();
        in0 = 32'h0000_F0F1;
        repeat (3) cyc();
        rd(0, 2'd3, 32'h0000_F0F0, "multi_bit_rise");
        cyc();

        // Any-edge / level-irq instance.
        wr(1, 2'd2, 32'hFFFF_FFFF);
        rd(1, 2'd2, 32'h0000_00FF, "narrow_zero_ext");
        cyc();
        idle(1);
        wr(1, 2'd2, 32'h1);
        in1 = 8'h01;
        cyc();
        cyc();
        chk_irq(1, 1'b0, "lvl_irq_lag");
        rd(1, 2'd0, 32'h1, "lvl_data_high");
        cyc();
        chk_irq(1, 1'b1, "lvl_irq_high");
        rd(1, 2'd3, 32'h1, "any_edge_rise");
        cyc();
        idle(1);
        wr(1, 2'd3, 32'h1);
        rd(1, 2'd3, 32'h0, "any_edge_clear");
        in1 = 8'h00;
        cyc();
        cyc();
        chk_irq(1, 1'b1, "lvl_irq_hold");
        cyc();
        chk_irq(1, 1'b0, "lvl_irq_low");
        rd(1, 2'd3, 32'h1, "any_edge_fall");
        cyc();
        idle(1);

        // Asynchronous reset mid-cycle with capture and mask populated.
        in0 = 32'h0;
        repeat (3) cyc();
        wr(0, 2'd3, 32'hFFFF_FFFF);
        wr(0, 2'd2, 32'hF);
        in0 = 32'hF;
        repeat (3) cyc();
        rd(0, 2'd3, 32'hF, "pre_reset_cap");
        cyc();
        chk_irq(0, 1'b1, "pre_reset_irq");
        cyc();
        rd(0, 2'd3, 32'h0, "async_rst_cap");
        chk_irq(0, 1'b0, "async_rst_irq");
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_irq0_now: got %b, expected 0", irq0);
        end
        n_checks++;
        if (irq1 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst_irq1_now: got %b, expected 0", irq1);
        end
        n_checks++;
        if (bus0.readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst_cap_now: got 0x%08h, expected 0x00000000", bus0.readdata);
        end
        cyc();
        rd(0, 2'd2, 32'h0, "async_rst_mask");
        cyc();
        rd(0, 2'd0, 32'h0, "async_rst_data");
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd(0, 2'd3, 32'h0, "rearm_no_capture");
            cyc();
        end
        rd(0, 2'd0, 32'hF, "rearm_data");
        chk_irq(0, 1'b0, "rearm_irq");
        cyc();
        idle(0);

        @(negedge clk);
        #1;
        if (n_checks < 12) begin
            n_fail++;
            $display("FAIL check_count: only %0d checks evaluated", n_checks);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_pio_in_capture.md
Name: nios_pio_in_capture

Overview:
- Avalon-MM slave input PIO: samples an external WIDTH-bit bus through a synchronizer and exposes it to the Nios II for reading.
- Latches selected input edges into a sticky edge-capture register and raises a maskable interrupt.
- Read-side counterpart of the system's output PIOs.
- Sits on the Nios II data master interconnect; irq goes to the processor IRQ input.

Parameters:
- WIDTH, 32, width of in_port and of every register; 1..32.
- SYNC_STAGES, 2, synchronizer flop depth on in_port; 2..4.
- EDGE_TYPE, 0, capture on: 0 = rising, 1 = falling, 2 = any edge.
- IRQ_TYPE, 1, 0 = level IRQ from synchronized data, 1 = edge IRQ from edge-capture.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH ignored.
- readdata  output  32  read data; zero-extended above WIDTH.
- in_port  input  WIDTH  asynchronous external inputs.
- irq  output  1  active-high interrupt to CPU.

Behaviour:
- Reset is asynchronous and active-low; all flops clear on reset_n low, independent of clk.
- Reset values: sync chain 0, prev 0, data_reg 0, irq_mask 0, edge_capture 0, arm counter 0, irq 0, readdata 0.
- Register map (read latency 0, readdata combinational from registers):
  - addr 0: data_reg (last synchronizer stage); read-only, writes ignored.
  - addr 1: reserved; reads 0, writes ignored.
  - addr 2: irq_mask; read/write.
  - addr 3: edge_capture; read, write-1-to-clear per bit.
- A write occurs when chipselect=1 and write_n=0 at a clk rising edge. Reads have no side effects.
- Synchronizer timing: a change on in_port stable before edge k appears in data_reg after edge k+SYNC_STAGES-1.
- Edge detect: prev <= data_reg each cycle.
  - rise = data_reg & ~prev
  - fall = ~data_reg & prev
  - edge_capture bit sets at the edge following the data_reg change.
- Arming:
  - A 3-bit arm counter counts up from 0 after reset, saturating at SYNC_STAGES+1.
  - Edge detection is suppressed while counter < SYNC_STAGES+1, so inputs already high at reset release do not capture.
  - Reset mid-operation restarts arming.
- Same-cycle set and clear on one bit: set wins, bit stays 1. Clearing bits with writedata=0 leaves them unchanged.
- Edge capture is sticky, independent of irq_mask, and captured regardless of IRQ_TYPE.
- irq is registered and updates one cycle after its source:
  - IRQ_TYPE=1: irq <= |(edge_capture & irq_mask).
  - IRQ_TYPE=0: irq <= |(data_reg & irq_mask).
- Glitch handling: a pulse shorter than one clk period may be missed. Any pulse captured by the first sync stage propagates and is captured.
- Bit-independent: simultaneous edges on multiple bits set all corresponding bits in the same cycle.

Test Plan:
- Reset with in_port=0x0000_00FF held high → after release, edge_capture reads 0 for 10 cycles; addr 0 reads 0x0000_00FF from cycle SYNC_STAGES onward.
- EDGE_TYPE=0: in_port 0→0x5 at edge k → addr 0 reads 0x5 after edge k+1; addr 3 reads 0x5 after edge k+2. Then 0x5→0 → addr 3 still 0x5.
- Set irq_mask=0x4 and edge_capture=0x5 → irq=1 one cycle after the mask write. Write 0x4 to addr 3 → edge_capture=0x1 and irq=0 one cycle later.
- Write 0x1 to addr 3 in the same cycle a new rising edge on bit 0 is detected → bit 0 reads 1.
- EDGE_TYPE=2, IRQ_TYPE=0, mask=0x1: toggle bit 0 high then low → edge_capture bit 0 sets on each toggle; irq follows data_reg bit 0 with 1 cycle delay.
- Assert reset_n low asynchronously mid-cycle with mask=0xF and capture=0xF → irq and all registers read 0 immediately; arming restarts after release.
